// File: rtl/mic_pkg.sv
// Shared types, widths and sample conversion helper for the mic frame packer.
package mic_pkg;

    localparam int unsigned MIC_SAMPLE_W = 16;
    localparam int unsigned MIC_WORD_W   = 32;

    typedef enum logic {
        HALF_EMPTY = 1'b0,
        HALF_FULL  = 1'b1
    } pack_state_t;

    // Offset binary -> two's complement: subtract mid-scale, then sign-extend from bit bits-1.
    function automatic logic [MIC_SAMPLE_W-1:0] offset_to_signed(
        input logic [MIC_SAMPLE_W-1:0] s,
        input int unsigned             bits
    );
        logic [MIC_SAMPLE_W-1:0] d;
        logic                    sign;
        d    = s - (MIC_SAMPLE_W'(1) << (bits - 1));
        sign = d[4'(bits - 1)];
        for (int unsigned i = 0; i < MIC_SAMPLE_W; i++) begin
            if (i >= bits) d[4'(i)] = sign;
        end
        return d;
    endfunction

endpackage

// File: rtl/mic_sample_condition.sv
// Masks one raw sample to its valid ADC bits; with MIC_FRAME_PACKER_SIGNED_EN
// defined the masked offset-binary value is also converted to two's complement.
module mic_sample_condition
    import mic_pkg::*;
#(
    parameter int unsigned SAMPLE_BITS = 12
) (
    input  logic [MIC_SAMPLE_W-1:0] sample_i,
    output logic [MIC_SAMPLE_W-1:0] sample_c_o
);

    localparam logic [MIC_SAMPLE_W-1:0] MASK =
        MIC_SAMPLE_W'((33'h1 << SAMPLE_BITS) - 33'h1);

    logic [MIC_SAMPLE_W-1:0] masked;

    assign masked = sample_i & MASK;

`ifdef MIC_FRAME_PACKER_SIGNED_EN
    assign sample_c_o = offset_to_signed(masked, SAMPLE_BITS);
`else
    assign sample_c_o = masked;
`endif

endmodule

// File: rtl/mic_frame_packer.sv
// Packs pairs of 16-bit mic samples into 32-bit AXI-Stream words framed by tlast
// every FRAME_WORDS words, with a flush request to close a partial frame.
// Optional: MIC_FRAME_PACKER_SIGNED_EN selects signed (two's complement) samples.
module mic_frame_packer
    import mic_pkg::*;
#(
    parameter int unsigned FRAME_WORDS            = 256,
    parameter int unsigned SAMPLE_BITS            = 12,
    parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 16,
    parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 32
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                s00_axis_tvalid,
    output logic                                s00_axis_tready,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    output logic                                m00_axis_tvalid,
    input  logic                                m00_axis_tready,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                                m00_axis_tlast,
    input  logic                                flush,
    output logic                                frame_done
);

    localparam int unsigned CNT_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_WORDS - 1);

    pack_state_t             state_q, state_d;
    logic [MIC_SAMPLE_W-1:0] held_q, held_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    flush_pend_q, flush_pend_d;
    logic                    tvalid_q, tvalid_d;
    logic [MIC_WORD_W-1:0]   tdata_q, tdata_d;
    logic                    tlast_q, tlast_d;
    logic                    frame_done_q, frame_done_d;

    logic [MIC_SAMPLE_W-1:0] sample_c;
    logic                    out_free_c;
    logic                    in_acc_c;
    logic                    drain_c;

    mic_sample_condition #(
        .SAMPLE_BITS (SAMPLE_BITS)
    ) u_cond (
        .sample_i   (s00_axis_tdata),
        .sample_c_o (sample_c)
    );

    // Handshake qualifiers; the output slot is reusable when empty or draining this cycle.
    assign drain_c         = tvalid_q && m00_axis_tready;
    assign out_free_c      = !tvalid_q || m00_axis_tready;
    assign s00_axis_tready = !reset && !flush_pend_q && out_free_c;
    assign in_acc_c        = s00_axis_tvalid && s00_axis_tready;

    // Next-state: pairing FSM, frame counter, flush servicing and output register.
    always_comb begin
        state_d      = state_q;
        held_d       = held_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q || flush;
        tvalid_d     = tvalid_q;
        tdata_d      = tdata_q;
        tlast_d      = tlast_q;
        frame_done_d = drain_c && tlast_q;

        if (drain_c) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end

        if (flush_pend_q && out_free_c) begin
            flush_pend_d = flush;
            if (state_q == HALF_FULL) begin
                tvalid_d = 1'b1;
                tdata_d  = {MIC_SAMPLE_W'(0), held_q};
                tlast_d  = 1'b1;
                cnt_d    = '0;
                state_d  = HALF_EMPTY;
            end else if (cnt_q != '0) begin
                // Previous word left without tlast; close the frame with a zero word.
                tvalid_d = 1'b1;
                tdata_d  = '0;
                tlast_d  = 1'b1;
                cnt_d    = '0;
            end
        end else if (in_acc_c) begin
            if (state_q == HALF_EMPTY) begin
                held_d  = sample_c;
                state_d = HALF_FULL;
            end else begin
                tvalid_d = 1'b1;
                tdata_d  = {sample_c, held_q};
                tlast_d  = (cnt_q == CNT_LAST);
                cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
                state_d  = HALF_EMPTY;
            end
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= HALF_EMPTY;
            held_q       <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            tvalid_q     <= 1'b0;
            tdata_q      <= '0;
            tlast_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            held_q       <= held_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            tvalid_q     <= tvalid_d;
            tdata_q      <= tdata_d;
            tlast_q      <= tlast_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign m00_axis_tvalid = tvalid_q;
    assign m00_axis_tdata  = tdata_q;
    assign m00_axis_tlast  = tlast_q;
    assign m00_axis_tstrb  = '1;
    assign frame_done      = frame_done_q;

endmodule

// File: tb/tb_mic_frame_packer.sv
// Directed bench for mic_frame_packer (FRAME_WORDS=4, SAMPLE_BITS=12).
module tb_mic_frame_packer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [15:0] s_tdata = 16'h0;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb;
    logic        m_tlast;
    logic        flush = 1'b0;
    logic        frame_done;

    int tests_run = 0;
    int tests_failed = 0;

    logic [32:0] q[$];
    int fd_cnt = 0;
    int acc_cnt = 0;
    int stall_cnt = 0;
    bit mon_en = 1'b0;
    int base_q;

    mic_frame_packer #(
        .FRAME_WORDS (4),
        .SAMPLE_BITS (12)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tready (s_tready),
        .s00_axis_tdata  (s_tdata),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tready (m_tready),
        .m00_axis_tdata  (m_tdata),
        .m00_axis_tstrb  (m_tstrb),
        .m00_axis_tlast  (m_tlast),
        .flush           (flush),
        .frame_done      (frame_done)
    );

    always #5 clock = ~clock;

    // Passive monitor, sampled mid-cycle.
    always @(negedge clock) begin
        if (mon_en) begin
            if (m_tvalid && m_tready) q.push_back({m_tlast, m_tdata});
            if (frame_done) fd_cnt++;
            if (s_tvalid && s_tready) acc_cnt++;
            if (s_tvalid && !s_tready) stall_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_word(input string tag, input int idx, input logic exp_last,
                              input logic [31:0] exp_data);
        logic [63:0] got;
        if (base_q + idx < q.size()) got = 64'(q[base_q + idx]);
        else got = 'x;
        check(tag, got, {31'b0, exp_last, exp_data});
    endtask

    // Expected conditioned sample for SAMPLE_BITS=12.
    function automatic logic [15:0] cond(input logic [15:0] s);
        logic [15:0] m;
        m = s & 16'h0FFF;
`ifdef MIC_FRAME_PACKER_SIGNED_EN
        m = m - 16'h0800;
        m = {{4{m[11]}}, m[11:0]};
`endif
        return m;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [15:0] d);
        s_tvalid = 1'b1;
        s_tdata  = d;
        step();
        s_tvalid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        s_tvalid = 1'b0;
        flush = 1'b0;
        m_tready = 1'b1;
        step();
        step();
        reset = 1'b0;
        base_q = q.size();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fd0, acc0, st0, unstable, sz;
        logic [31:0] held_word;

        // Reset values
        step();
        mon_en = 1'b1;
        step();
        check("rst_tvalid", 64'(m_tvalid), 64'h0);
        check("rst_tdata", 64'(m_tdata), 64'h0);
        check("rst_tlast", 64'(m_tlast), 64'h0);
        check("rst_frame_done", 64'(frame_done), 64'h0);
        check("rst_s_tready", 64'(s_tready), 64'h0);
        check("tstrb", 64'(m_tstrb), 64'hF);
        reset = 1'b0;
        base_q = q.size();

        // Basic pair and latency
        send(16'h0123);
        check("lat_tvalid_first", 64'(m_tvalid), 64'h0);
        send(16'h0456);
        check("lat_tvalid", 64'(m_tvalid), 64'h1);
        check("lat_tdata", 64'(m_tdata), 64'({cond(16'h0456), cond(16'h0123)}));
        check("lat_tlast", 64'(m_tlast), 64'h0);

        // Full frame, back-to-back
        do_reset();
        fd0 = fd_cnt; st0 = stall_cnt;
        for (int i = 0; i < 8; i++) send(16'(16'h0100 + i));
        repeat (3) step();
        check("frm_count", 64'(q.size() - base_q), 64'd4);
        for (int w = 0; w < 4; w++)
            check_word("frm_word", w, (w == 3),
                       {cond(16'(16'h0100 + 2*w + 1)), cond(16'(16'h0100 + 2*w))});
        check("frm_done_pulses", 64'(fd_cnt - fd0), 64'd1);
        check("frm_no_stall", 64'(stall_cnt - st0), 64'd0);

        // Masking / sign conversion
        do_reset();
        send(16'hF123);
        send(16'h0FFF);
        repeat (2) step();
`ifdef MIC_FRAME_PACKER_SIGNED_EN
        check_word("mask_word", 0, 1'b0, 32'h07FF_F923);
`else
        check_word("mask_word", 0, 1'b0, 32'h0FFF_0123);
`endif

        // Backpressure: downstream stalled for 10 cycles
        do_reset();
        acc0 = acc_cnt;
        m_tready = 1'b0;
        send(16'h0111);
        send(16'h0222);
        held_word = {cond(16'h0222), cond(16'h0111)};
        s_tvalid = 1'b1;
        s_tdata  = 16'h0333;
        unstable = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (m_tvalid !== 1'b1 || m_tdata !== held_word || m_tlast !== 1'b0) unstable++;
        end
        check("bp_stable", 64'(unstable), 64'd0);
        check("bp_s_tready_low", 64'(s_tready), 64'h0);
        check("bp_accepted", 64'(acc_cnt - acc0), 64'd2);
        m_tready = 1'b1;
        step();
        s_tdata = 16'h0444;
        step();
        s_tvalid = 1'b0;
        repeat (3) step();
        check("bp_count", 64'(q.size() - base_q), 64'd2);
        check_word("bp_word0", 0, 1'b0, held_word);
        check_word("bp_word1", 1, 1'b0, {cond(16'h0444), cond(16'h0333)});

        // Flush with a held half-sample
        do_reset();
        fd0 = fd_cnt;
        send(16'h0010);
        send(16'h0020);
        send(16'h0030);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_s_tready_pending", 64'(s_tready), 64'h0);
        repeat (3) step();
        check_word("fl_word0", 0, 1'b0, {cond(16'h0020), cond(16'h0010)});
        check_word("fl_word1", 1, 1'b1, {16'h0000, cond(16'h0030)});
        check("fl_done_pulses", 64'(fd_cnt - fd0), 64'd1);
        // Counter restarted: next full frame ends on its 4th word
        for (int i = 0; i < 8; i++) send(16'(16'h0200 + i));
        repeat (3) step();
        check_word("fl_next_w0", 2, 1'b0, {cond(16'h0201), cond(16'h0200)});
        check_word("fl_next_w3", 5, 1'b1, {cond(16'h0207), cond(16'h0206)});
        // Flush with nothing held and counter at zero
        sz = q.size();
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (3) step();
        check("fl_empty_no_word", 64'(q.size() - sz), 64'd0);
        // Flush in HALF_EMPTY with a partial frame closes with a zero word
        send(16'h0051);
        send(16'h0052);
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (3) step();
        check_word("fl_zero_w0", 6, 1'b0, {cond(16'h0052), cond(16'h0051)});
        check_word("fl_zero_w1", 7, 1'b1, 32'h0);

        // Reset mid-operation
        do_reset();
        m_tready = 1'b0;
        send(16'h0AAA);
        send(16'h0BBB);
        check("mr_tvalid_before", 64'(m_tvalid), 64'h1);
        reset = 1'b1;
        step();
        check("mr_tvalid_after", 64'(m_tvalid), 64'h0);
        reset = 1'b0;
        m_tready = 1'b1;
        send(16'h0CCC);
        reset = 1'b1;
        step();
        reset = 1'b0;
        send(16'h0012);
        send(16'h0034);
        repeat (3) step();
        check("mr_count", 64'(q.size() - base_q), 64'd1);
        check_word("mr_word", 0, 1'b0, {cond(16'h0034), cond(16'h0012)});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mic_frame_packer.md
Name: mic_frame_packer

Overview:
- Sits directly downstream of the mic sample stream (16-bit AXI-Stream samples out of the sample FIFO) and upstream of the DMA/S2MM path.
- Masks each sample to its valid ADC bits and packs two consecutive samples into one 32-bit word.
- Frames the output with tlast every FRAME_WORDS words, so DMA transfers align to fixed-length audio frames.
- Supports an explicit flush to close a partial frame.

Parameters:
- FRAME_WORDS, 256, output words per frame; legal range 2..65536.
- SAMPLE_BITS, 12, valid low-order bits of each input sample; legal range 1..16.
- C_S00_AXIS_TDATA_WIDTH, 16, input sample width; fixed at 16.
- C_M00_AXIS_TDATA_WIDTH, 32, output word width; fixed at 2*C_S00_AXIS_TDATA_WIDTH.

Ports:
- clock  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high reset.
- s00_axis_tvalid  in  1  input sample valid.
- s00_axis_tready  out  1  input sample accepted when high with tvalid.
- s00_axis_tdata  in  16  input sample; bits [SAMPLE_BITS-1:0] meaningful.
- m00_axis_tvalid  out  1  output word valid.
- m00_axis_tready  in  1  downstream ready.
- m00_axis_tdata  out  32  packed word: older sample in [15:0], newer in [31:16].
- m00_axis_tstrb  out  4  constant all ones.
- m00_axis_tlast  out  1  last word of frame.
- flush  in  1  one-cycle request to close the current frame.
- frame_done  out  1  one-cycle pulse when a tlast word is accepted downstream.

Behaviour:
- Reset values, synchronous on the rising edge with reset=1:
  - m00_axis_tvalid=0, tdata=0, tlast=0, frame_done=0.
  - State HALF_EMPTY, word counter=0, flush-pending=0.
  - s00_axis_tready is 0 during reset.
- Reset mid-operation discards any held half-sample, any pending output word and the partial frame count.
- Output register:
  - A word is transferred when m00_axis_tvalid && m00_axis_tready.
  - Once asserted, tvalid, tdata and tlast are held stable until transferred.
- s00_axis_tready = !reset && (!m00_axis_tvalid || m00_axis_tready). This gives full throughput of one sample per cycle under continuous ready.
- Sample masking: each accepted sample is zero-extended from [SAMPLE_BITS-1:0]; upper bits are forced to 0.
- States:
  - HALF_EMPTY: on input accept, store the masked sample in the low-half register and go to HALF_FULL.
  - HALF_FULL: on input accept:
    - Load the output register with {new, held}, set tvalid=1.
    - Set tlast=1 if word counter == FRAME_WORDS-1.
    - Go to HALF_EMPTY.
- Latency: a word appears on m00 one cycle after the second sample of the pair is accepted.
- Word counter:
  - Increments when a word is loaded into the output register.
  - Wraps to 0 when a tlast word is loaded.
- frame_done pulses in the cycle a tlast word transfers downstream.
- Flush:
  - A flush pulse sets flush-pending.
  - Flush-pending is serviced on the first cycle in which the output register is free or being drained:
    - In HALF_FULL: emit {16'h0, held} with tlast=1, counter→0, go to HALF_EMPTY.
    - In HALF_EMPTY with counter≠0: the most recently loaded word already left without tlast, so emit word 32'h0 with tlast=1, counter→0.
    - In HALF_EMPTY with counter==0: no output, pending cleared.
  - While flush-pending, s00_axis_tready=0.
  - A flush arriving in the same cycle as an input accept takes effect after that sample is absorbed; the sample is included in the closed frame.
- Simultaneous output drain and new load in one cycle is legal; there is no bubble.

Optional Feature:
- Macro: MIC_FRAME_PACKER_SIGNED_EN.
- Defined: each masked sample is converted from offset binary to two's complement: subtract 2^(SAMPLE_BITS-1), then sign-extend to 16 bits. Example for SAMPLE_BITS=12: 0x800→0x0000, 0x000→0xF800, 0xFFF→0x07FF.
- Not defined: zero-extended unsigned samples as described above.
- Flush padding is 16'h0 in both modes.

Decomposition:
- Shared package mic_pkg holds:
  - Enum pack_state_t {HALF_EMPTY, HALF_FULL}.
  - Constants MIC_SAMPLE_W=16 and MIC_WORD_W=32.
  - Function for the offset-binary-to-signed conversion.
- One sub-module is natural: mic_sample_condition, a combinational mask/sign-convert of one sample, instantiated once on the input path.
- Framing counter and output register stay in the top module.

Test Plan:
- Reset, then samples 0x0123, 0x0456 with continuous ready → one word 0x04560123, tlast=0, appearing one cycle after the second accept.
- FRAME_WORDS=4, 8 samples streamed back-to-back → 4 words, tlast only on word 4, frame_done pulses once; s00_axis_tready stays 1 throughout.
- Input 0xF123 with SAMPLE_BITS=12 → low half 0x0123; with MIC_FRAME_PACKER_SIGNED_EN, 0xF123 → 0xF923.
- m00_axis_tready held low for 10 cycles while 3 samples are offered → s00_axis_tready drops after the first word forms, output stays stable, no loss; release → data in order.
- 3 samples, then flush → words 0x..., then {0x0000, s2} with tlast=1, counter reset. Flush with nothing held and counter=0 → no output.
- Assert reset while in HALF_FULL with tvalid high → next cycle tvalid=0; a new pair after reset yields a word with only post-reset samples.
